// File: rtl/fp_mul_result_stage.sv
// Registered 2-entry result buffer behind the single-precision multiplier.
// Optional per-flag counters are enabled by FP_MUL_RESULT_FLAG_CNT_EN.
module fp_mul_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_exception,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       occupancy
`ifdef FP_MUL_RESULT_FLAG_CNT_EN
  ,
  output logic [CNT_W-1:0] exc_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count
`endif
);

  logic [31:0] res_q [2];
  logic [2:0]  flg_q [2];
  logic        head;
  logic        tail;
  logic [1:0]  occ;
  logic        push;
  logic        pop;
  logic [2:0]  in_flags;

  assign in_flags     = {in_exception, in_overflow, in_underflow};
  assign in_ready     = (occ != 2'd2);
  assign out_valid    = (occ != 2'd0);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign out_result   = res_q[head];
  assign out_flags    = flg_q[head];
  assign occupancy    = occ;

  // FIFO storage, pointers and occupancy; entries written only on push
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      flg_q[0] <= '0;
      flg_q[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (push) begin
        res_q[tail] <= in_result;
        flg_q[tail] <= in_flags;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      if (push && !pop) occ <= occ + 2'd1;
      else if (pop && !push) occ <= occ - 2'd1;
    end
  end

  // Sticky flags: clear takes effect before the incoming set
  always_ff @(posedge clk) begin
    if (rst) sticky_flags <= '0;
    else if (sticky_clr) sticky_flags <= push ? in_flags : 3'b000;
    else if (push) sticky_flags <= sticky_flags | in_flags;
  end

  // Delivered-result counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (pop && op_count != '1) op_count <= op_count + 1'b1;
  end

`ifdef FP_MUL_RESULT_FLAG_CNT_EN
  logic [CNT_W-1:0] fcnt [3];

  assign exc_count = fcnt[2];
  assign ovf_count = fcnt[1];
  assign unf_count = fcnt[0];

  // Per-flag saturating counters; clear wins but a coincident hit counts as 1
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) fcnt[i] <= '0;
      else if (sticky_clr) fcnt[i] <= CNT_W'(push & in_flags[i]);
      else if (push && in_flags[i] && fcnt[i] != '1)
        fcnt[i] <= fcnt[i] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Scoreboard bench for fp_mul_result_stage (CNT_W=4).
// Checks ordering, stall stability, sticky flags and counter saturation.
module tb_fp_mul_result_stage;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_exception;
  logic             in_overflow;
  logic             in_underflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       occupancy;
`ifdef FP_MUL_RESULT_FLAG_CNT_EN
  logic [CNT_W-1:0] exc_count;
  logic [CNT_W-1:0] ovf_count;
  logic [CNT_W-1:0] unf_count;
  logic [CNT_W-1:0] m_fc [3];
`endif

  fp_mul_result_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_exception(in_exception),
    .in_overflow(in_overflow),
    .in_underflow(in_underflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags),
    .sticky_flags(sticky_flags),
    .sticky_clr(sticky_clr),
    .op_count(op_count),
    .occupancy(occupancy)
`ifdef FP_MUL_RESULT_FLAG_CNT_EN
    ,
    .exc_count(exc_count),
    .ovf_count(ovf_count),
    .unf_count(unf_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0]      sb [$];
  logic [2:0]       m_sticky;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == SAT) ? c : c + 1'b1;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_sticky = '0;
    m_cnt    = '0;
`ifdef FP_MUL_RESULT_FLAG_CNT_EN
    for (int i = 0; i < 3; i++) m_fc[i] = '0;
`endif
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_ores", out_result, 32'd0);
    check("rst_oflg", 32'(out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_cnt", 32'(op_count), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
  endtask

  // one clock: drive, check head before edge, update model, check state
  task automatic cyc(input logic v, input logic [31:0] r,
                     input logic [2:0] f, input logic ordy,
                     input logic clr);
    logic p, q;
    in_valid     = v;
    in_result    = v ? r : 32'hxxxx_xxxx;
    in_exception = v ? f[2] : 1'bx;
    in_overflow  = v ? f[1] : 1'bx;
    in_underflow = v ? f[0] : 1'bx;
    out_ready    = ordy;
    sticky_clr   = clr;
    p = v && (sb.size() != 2);
    q = ordy && (sb.size() != 0);
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(sb.size() != 2));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_result", out_result, sb[0][31:0]);
      check("out_flags", 32'(out_flags), 32'(sb[0][34:32]));
    end
    @(posedge clk);
    #1;
    if (q) begin
      void'(sb.pop_front());
      m_cnt = sat_inc(m_cnt);
    end
    if (p) sb.push_back({f, r});
    if (clr) m_sticky = p ? f : 3'b000;
    else if (p) m_sticky = m_sticky | f;
`ifdef FP_MUL_RESULT_FLAG_CNT_EN
    for (int i = 0; i < 3; i++) begin
      if (clr) m_fc[i] = CNT_W'(p & f[i]);
      else if (p && f[i]) m_fc[i] = sat_inc(m_fc[i]);
    end
    check("exc_count", 32'(exc_count), 32'(m_fc[2]));
    check("ovf_count", 32'(ovf_count), 32'(m_fc[1]));
    check("unf_count", 32'(unf_count), 32'(m_fc[0]));
`endif
    check("occupancy", 32'(occupancy), 32'(sb.size()));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    check("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  initial begin
    in_result    = '0;
    in_exception = 1'b0;
    in_overflow  = 1'b0;
    in_underflow = 1'b0;
    do_reset();

    // single op
    cyc(1'b1, 32'h40C0_0000, 3'b000, 1'b1, 1'b0);
    check("single_ovalid", 32'(out_valid), 32'd1);
    check("single_res", out_result, 32'h40C0_0000);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("single_cnt", 32'(op_count), 32'd1);
    check("single_occ", 32'(occupancy), 32'd0);

    // back-pressure: fill, third offer rejected, then drain
    cyc(1'b1, 32'h3F80_0000, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4000_0000, 3'b000, 1'b0, 1'b0);
    check("bp_full_occ", 32'(occupancy), 32'd2);
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'h4040_0000, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4040_0000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, 32'h4040_0000, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("bp_cnt", 32'(op_count), 32'd4);

    // streaming 1..8
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 32'(i), 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("stream_cnt", 32'(op_count), 32'd12);

    // flags and sticky clear priority
    cyc(1'b1, 32'hFFFF_FFFF, 3'b100, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0000, 3'b001, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("sticky_101", 32'(sticky_flags), 32'b101);
    cyc(1'b1, 32'h3F80_0000, 3'b010, 1'b1, 1'b1);
    check("sticky_clr_set", 32'(sticky_flags), 32'b010);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("sat_opcnt_early", 32'(op_count), 32'd15);

    // reset mid-operation
    cyc(1'b1, 32'h1111_1111, 3'b110, 1'b0, 1'b0);
    cyc(1'b1, 32'h2222_2222, 3'b001, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 32'h40C0_0000, 3'b000, 1'b1, 1'b0);
    check("post_rst_res", out_result, 32'h40C0_0000);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("post_rst_cnt", 32'(op_count), 32'd1);

    // op_count saturation over 17 pops
    do_reset();
    for (int i = 0; i < 17; i++)
      cyc(1'b1, 32'(i * 3 + 7), 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("sat_opcnt", 32'(op_count), 32'd15);

`ifdef FP_MUL_RESULT_FLAG_CNT_EN
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'hFFFF_FFFF, 3'b100, 1'b1, 1'b0);
    check("sat_exc", 32'(exc_count), 32'd15);
    cyc(1'b1, 32'hFFFF_FFFF, 3'b100, 1'b1, 1'b1);
    check("exc_clr_hit", 32'(exc_count), 32'd1);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
